// File: rtl/pool_window_gen.sv
// ---------------------------------------------------------------------------
// PoolWindowGen (module pool_window_gen)
//
// Purpose:
//    Turns a raster-order stream of signed 8-bit conv pixels into the
//    non-overlapping 2x2 windows consumed by a downstream max-pool stage.
//    Even rows are parked in a one-row line buffer. On odd rows the
//    even-column pixel is held in a register. The odd-column pixel then
//    completes the window, which is loaded into the output register on the
//    same clock edge.
//
// Ports:
//    clk        in   1   single clock, rising edge
//    rst        in   1   synchronous reset, active-high
//    in_valid   in   1   in_data carries a valid pixel
//    in_ready   out  1   block accepts in_data this cycle
//    in_data    in   8   signed pixel, row-major, column 0 first
//    out_valid  out  1   win0..win3 / out_last hold a valid window
//    out_ready  in   1   downstream accepts the window
//    win0..3    out  8   top-left, top-right, bottom-left, bottom-right
//    out_last   out  1   window is the last one of the frame
//
// Parameters:
//    IMG_W, IMG_H  feature-map width/height; both even and >= 2
//
// Configuration macro:
//    POOL_WIN_RELU_EN  when defined, negative pixels are clamped to 0 before
//                      they are stored or placed in a window
// ---------------------------------------------------------------------------
module pool_window_gen #(
   parameter int IMG_W = 24,
   parameter int IMG_H = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic signed [7:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic signed [7:0] win0,
   output logic signed [7:0] win1,
   output logic signed [7:0] win2,
   output logic signed [7:0] win3,
   output logic              out_last
);

   localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic {
      EVEN_ROW = 1'b0,
      ODD_ROW  = 1'b1
   } state_t;

   state_t             r_state;
   logic [CW-1:0]      r_col;
   logic [RW-1:0]      r_row;
   logic signed [7:0]  r_hold;
   logic signed [7:0]  r_lbuf [IMG_W];
   logic               r_outValid;
   logic               r_outLast;
   logic signed [7:0]  r_win0;
   logic signed [7:0]  r_win1;
   logic signed [7:0]  r_win2;
   logic signed [7:0]  r_win3;

   logic signed [7:0]  w_pix;
   logic               w_inXfer;
   logic               w_colLast;
   logic               w_rowLast;
   logic [CW-1:0]      w_colPrev;

   // Optional rectification. Every consumer of the incoming pixel (line
   // buffer, hold register, window) sees the same value, so clamping here
   // covers all paths at once.
`ifdef POOL_WIN_RELU_EN
   assign w_pix = in_data[7] ? 8'sd0 : in_data;
`else
   assign w_pix = in_data;
`endif

   // Only the window-completing pixel (odd row, odd column) must wait for
   // room in the output register. Every other pixel goes into the line
   // buffer or the hold register and can always be taken.
   assign in_ready  = (r_state == EVEN_ROW) || !r_col[0] || !r_outValid || out_ready;
   assign w_inXfer  = in_valid && in_ready;
   assign w_colLast = (r_col == COL_LAST);
   assign w_rowLast = (r_row == ROW_LAST);

   // A window is completed only at an odd column. Its left-hand column is
   // therefore the current column with bit 0 cleared.
   assign w_colPrev = r_col & ~CW'(1);

   // Line buffer holding the even row of the current row pair. It has no
   // reset: each entry is rewritten on the even row before the odd row
   // reads it.
   always_ff @(posedge clk) begin
      if (!rst && w_inXfer && (r_state == EVEN_ROW)) begin
         r_lbuf[r_col] <= w_pix;
      end
   end

   // Main control. This block advances the raster position and toggles the
   // even/odd row state at each row end. It also captures the bottom-left
   // pixel and assembles the registered output window. When a completing
   // input arrives in the same cycle as an output transfer, the later
   // assignment below wins. The new window then replaces the old one and
   // out_valid stays high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= EVEN_ROW;
         r_col      <= '0;
         r_row      <= '0;
         r_hold     <= '0;
         r_outValid <= 1'b0;
         r_outLast  <= 1'b0;
         r_win0     <= '0;
         r_win1     <= '0;
         r_win2     <= '0;
         r_win3     <= '0;
      end else begin
         if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
         end
         if (w_inXfer) begin
            if (r_state == ODD_ROW) begin
               if (!r_col[0]) begin
                  r_hold <= w_pix;
               end else begin
                  r_win0     <= r_lbuf[w_colPrev];
                  r_win1     <= r_lbuf[r_col];
                  r_win2     <= r_hold;
                  r_win3     <= w_pix;
                  r_outValid <= 1'b1;
                  r_outLast  <= w_rowLast && w_colLast;
               end
            end
            if (w_colLast) begin
               r_col   <= '0;
               r_row   <= w_rowLast ? '0 : r_row + 1'b1;
               r_state <= (r_state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

   assign out_valid = r_outValid;
   assign out_last  = r_outLast;
   assign win0      = r_win0;
   assign win1      = r_win1;
   assign win2      = r_win2;
   assign win3      = r_win3;

endmodule
